// File: rtl/shifter_seq.sv
// ---------------------------------------------------------------------------
// shifter_seq
//   Parametrised multi-cycle universal shift register. A command (mode plus
//   shift amount) is taken on a start strobe while idle; the register then
//   shifts one bit per clock until the amount is used up and signals the end
//   of the command with a one-cycle done pulse. Serial in/out pins allow
//   chaining several blocks.
//
// Parameters
//   WIDTH   data width in bits (>= 2)
//   AMT_W   width of the shift-amount port (>= 1)
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset
//   start    in   1      command strobe, accepted only while busy = 0
//   chos     in   3      mode, sampled with start
//   amt      in   AMT_W  shift count, sampled with start
//   inp      in   WIDTH  parallel load data (mode 1), sampled with start
//   ser_in   in   1      serial input bit for mode 5, sampled every shift edge
//   busy     out  1      high while a multi-cycle shift is in progress
//   done     out  1      one-cycle pulse after the last operation of a command
//   result   out  WIDTH  register contents
//   ser_out  out  1      bit most recently shifted out of result
//
// Modes
//   0 clear  1 load  2 logical right  3 logical left  4 arithmetic right
//   5 serial right (ser_in enters at the MSB)  6 rotate right  7 rotate left
// ---------------------------------------------------------------------------
module shifter_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       chos,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] inp,
    input  logic             ser_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ser_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [2:0]         mode_q;
    logic [2:0]         mode_n;
    logic [AMT_W-1:0]   count;
    logic [AMT_W-1:0]   count_n;
    logic [WIDTH-1:0]   result_n;
    logic               ser_out_n;
    logic               done_n;
    logic [2:0]         mode_sel;
    logic [WIDTH:0]     op_out;

    // One application of a mode to the register. The returned MSB is the
    // bit pushed out on ser_out; clear and load drive ser_out to 0.
    function automatic logic [WIDTH:0] shift_op(
        input logic [2:0]       mode,
        input logic [WIDTH-1:0] r,
        input logic [WIDTH-1:0] load_val,
        input logic             sin
    );
        logic [WIDTH:0] res;
        res = '0;
        case (mode)
            3'd0: res = {1'b0, {WIDTH{1'b0}}};
            3'd1: res = {1'b0, load_val};
            3'd2: res = {r[0], 1'b0, r[WIDTH-1:1]};
            3'd3: res = {r[WIDTH-1], r[WIDTH-2:0], 1'b0};
            3'd4: res = {r[0], r[WIDTH-1], r[WIDTH-1:1]};
            3'd5: res = {r[0], sin, r[WIDTH-1:1]};
            3'd6: res = {r[0], r[0], r[WIDTH-1:1]};
            3'd7: res = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
            default: res = '0;
        endcase
        return res;
    endfunction

    // While idle the operation comes straight from the command inputs so the
    // first shift happens on the accepting edge; during SHIFT the latched
    // mode is used and the command inputs are don't-care.
    assign mode_sel = (state == IDLE) ? chos : mode_q;
    assign op_out   = shift_op(mode_sel, result, inp, ser_in);

    // Next-state and datapath decision. Everything holds by default and done
    // is only raised on the edge that finishes a command, which makes it a
    // single-cycle pulse after registration.
    always_comb begin
        state_n   = state;
        mode_n    = mode_q;
        count_n   = count;
        result_n  = result;
        ser_out_n = ser_out;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    mode_n = chos;
                    if (chos <= 3'd1) begin
                        {ser_out_n, result_n} = op_out;
                        done_n                = 1'b1;
                    end else if (amt == '0) begin
                        done_n = 1'b1;
                    end else begin
                        {ser_out_n, result_n} = op_out;
                        count_n               = amt - AMT_W'(1);
                        if (amt == AMT_W'(1)) begin
                            done_n = 1'b1;
                        end else begin
                            state_n = SHIFT;
                        end
                    end
                end
            end
            SHIFT: begin
                {ser_out_n, result_n} = op_out;
                count_n               = count - AMT_W'(1);
                if (count == AMT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset wins over any command or shift in
    // progress and returns every output to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mode_q  <= '0;
            count   <= '0;
            result  <= '0;
            ser_out <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            mode_q  <= mode_n;
            count   <= count_n;
            result  <= result_n;
            ser_out <= ser_out_n;
            done    <= done_n;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_shifter_seq.sv
// ---------------------------------------------------------------------------
// tb_shifter_seq
//   Directed bench for shifter_seq (WIDTH=8, AMT_W=3). Each step drives the
//   inputs for one clock cycle and pushes the hand-derived register state
//   expected after the following rising edge into a scoreboard queue; the
//   entry is popped and compared 1 time unit after that edge.
// ---------------------------------------------------------------------------
module tb_shifter_seq;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             busy;
        logic             done;
        logic             ser_out;
    } expect_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       chos;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] inp;
    logic             ser_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ser_out;

    expect_t scoreboard[$];
    int      checks   = 0;
    int      failures = 0;

    shifter_seq #(
        .WIDTH(WIDTH),
        .AMT_W(AMT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .chos   (chos),
        .amt    (amt),
        .inp    (inp),
        .ser_in (ser_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ser_out(ser_out)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop one expected entry and compare every observable output against it.
    task automatic checkOutput(input string tag);
        expect_t e;
        checks++;
        assert (scoreboard.size() != 0)
        else begin
            failures++;
            $error("[TB] FAIL %s scoreboard empty: observed size=0 expected size>0", tag);
        end
        if (scoreboard.size() != 0) begin
            e = scoreboard.pop_front();
            checks++;
            assert (result === e.result)
            else begin
                failures++;
                $error("[TB] FAIL %s result: observed=%h expected=%h", tag, result, e.result);
            end
            checks++;
            assert (busy === e.busy)
            else begin
                failures++;
                $error("[TB] FAIL %s busy: observed=%b expected=%b", tag, busy, e.busy);
            end
            checks++;
            assert (done === e.done)
            else begin
                failures++;
                $error("[TB] FAIL %s done: observed=%b expected=%b", tag, done, e.done);
            end
            checks++;
            assert (ser_out === e.ser_out)
            else begin
                failures++;
                $error("[TB] FAIL %s ser_out: observed=%b expected=%b", tag, ser_out, e.ser_out);
            end
        end
    endtask

    // Drive one cycle of inputs, queue the state expected after the next
    // rising edge, then sample just after that edge.
    task automatic applyStimulus(
        input string            tag,
        input logic             r,
        input logic             s,
        input logic [2:0]       c,
        input logic [AMT_W-1:0] a,
        input logic [WIDTH-1:0] d,
        input logic             si,
        input logic [WIDTH-1:0] exp_result,
        input logic             exp_busy,
        input logic             exp_done,
        input logic             exp_ser
    );
        expect_t e;
        rst    = r;
        start  = s;
        chos   = c;
        amt    = a;
        inp    = d;
        ser_in = si;
        e.result  = exp_result;
        e.busy    = exp_busy;
        e.done    = exp_done;
        e.ser_out = exp_ser;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        chos   = '0;
        amt    = '0;
        inp    = '0;
        ser_in = 1'b0;

        //                tag            rst  st  chos  amt   inp    si  result bsy dn ser
        applyStimulus("reset0",       1, 0, 3'd0, 3'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        applyStimulus("reset1",       1, 1, 3'd1, 3'd0, 8'hAA, 0, 8'h00, 0, 0, 0);

        // Load then arithmetic right by 3.
        applyStimulus("load_b4",      0, 1, 3'd1, 3'd0, 8'hB4, 0, 8'hB4, 0, 1, 0);
        applyStimulus("asr_1",        0, 1, 3'd4, 3'd3, 8'h00, 0, 8'hDA, 1, 0, 0);
        applyStimulus("asr_2",        0, 0, 3'd0, 3'd0, 8'h00, 0, 8'hED, 1, 0, 0);
        applyStimulus("asr_3",        0, 0, 3'd0, 3'd0, 8'h00, 0, 8'hF6, 0, 1, 1);
        applyStimulus("asr_hold",     0, 0, 3'd0, 3'd0, 8'h00, 0, 8'hF6, 0, 0, 1);

        // Rotate left by 2 from 81.
        applyStimulus("load_81",      0, 1, 3'd1, 3'd0, 8'h81, 0, 8'h81, 0, 1, 0);
        applyStimulus("rol_1",        0, 1, 3'd7, 3'd2, 8'h00, 0, 8'h03, 1, 0, 1);
        applyStimulus("rol_2",        0, 0, 3'd0, 3'd0, 8'h00, 0, 8'h06, 0, 1, 0);

        // Clear, then serial right with ser_in 1,1,0.
        applyStimulus("clear",        0, 1, 3'd0, 3'd5, 8'hFF, 0, 8'h00, 0, 1, 0);
        applyStimulus("ser_1",        0, 1, 3'd5, 3'd3, 8'h00, 1, 8'h80, 1, 0, 0);
        applyStimulus("ser_2",        0, 0, 3'd0, 3'd0, 8'h00, 1, 8'hC0, 1, 0, 0);
        applyStimulus("ser_3",        0, 0, 3'd0, 3'd0, 8'h00, 0, 8'h60, 0, 1, 0);

        // Logical right by 3 with a load attempted while busy (ignored).
        applyStimulus("lsr_1",        0, 1, 3'd2, 3'd3, 8'h00, 0, 8'h30, 1, 0, 0);
        applyStimulus("lsr_busyload", 0, 1, 3'd1, 3'd0, 8'hFF, 0, 8'h18, 1, 0, 0);
        applyStimulus("lsr_3",        0, 0, 3'd0, 3'd0, 8'h00, 0, 8'h0C, 0, 1, 0);

        // Single rotate right (amt=1 stays idle), then amt=0 keeps everything.
        applyStimulus("load_0d",      0, 1, 3'd1, 3'd0, 8'h0D, 0, 8'h0D, 0, 1, 0);
        applyStimulus("ror_amt1",     0, 1, 3'd6, 3'd1, 8'h00, 0, 8'h86, 0, 1, 1);
        applyStimulus("lsr_amt0",     0, 1, 3'd2, 3'd0, 8'h55, 0, 8'h86, 0, 1, 1);
        applyStimulus("amt0_after",   0, 0, 3'd0, 3'd0, 8'h00, 0, 8'h86, 0, 0, 1);

        // Reset during the second cycle of a 5-shift left command.
        applyStimulus("lsl_1",        0, 1, 3'd3, 3'd5, 8'h00, 0, 8'h0C, 1, 0, 1);
        applyStimulus("mid_reset",    1, 0, 3'd0, 3'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        applyStimulus("post_reset",   0, 0, 3'd0, 3'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        applyStimulus("load_a5",      0, 1, 3'd1, 3'd0, 8'hA5, 0, 8'hA5, 0, 1, 0);

        // Back-to-back commands started in each done cycle.
        applyStimulus("ror_1",        0, 1, 3'd6, 3'd2, 8'h00, 0, 8'hD2, 1, 0, 1);
        applyStimulus("ror_2",        0, 0, 3'd0, 3'd0, 8'h00, 0, 8'h69, 0, 1, 0);
        applyStimulus("b2b_rol",      0, 1, 3'd7, 3'd1, 8'h00, 0, 8'hD2, 0, 1, 0);
        applyStimulus("b2b_asr7_1",   0, 1, 3'd4, 3'd7, 8'h00, 0, 8'hE9, 1, 0, 0);
        applyStimulus("asr7_2",       0, 0, 3'd0, 3'd0, 8'h00, 0, 8'hF4, 1, 0, 1);
        applyStimulus("asr7_3",       0, 0, 3'd0, 3'd0, 8'h00, 0, 8'hFA, 1, 0, 0);
        applyStimulus("asr7_4",       0, 0, 3'd0, 3'd0, 8'h00, 0, 8'hFD, 1, 0, 0);
        applyStimulus("asr7_5",       0, 0, 3'd0, 3'd0, 8'h00, 0, 8'hFE, 1, 0, 1);
        applyStimulus("asr7_6",       0, 0, 3'd0, 3'd0, 8'h00, 0, 8'hFF, 1, 0, 0);
        applyStimulus("asr7_7",       0, 0, 3'd0, 3'd0, 8'h00, 0, 8'hFF, 0, 1, 1);
        applyStimulus("final_idle",   0, 0, 3'd0, 3'd0, 8'h00, 0, 8'hFF, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
